// File: rtl/axis_transpose_buffer.sv
// Corner-turn buffer: stores one N x N frame arriving row-major on the
// slave stream, then replays it column-major on the master stream.
module axis_transpose_buffer #(
    parameter int LOG2N  = 7,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              frame_done,
    output logic              err_tlast_early,
    output logic              err_tlast_missing
);

    localparam int               AW       = 2 * LOG2N;
    localparam int               DEPTH    = 1 << AW;
    localparam logic [LOG2N-1:0] COL_LAST = '1;
    localparam logic [AW-1:0]    CNT_LAST = '1;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_cnt;
    logic [AW-1:0]     rd_cnt;
    logic              issued_all;

    logic              s_fire;
    logic              wr_last;
    logic              m_fire;
    logic              advance;
    logic              rd_issue;
    logic              out_last;
    logic [AW-1:0]     rd_addr;
    logic [LOG2N-1:0]  wr_col;

    assign wr_col   = wr_cnt[LOG2N-1:0];
    assign s_fire   = s_axis_tvalid && s_axis_tready && (state == FILL);
    assign wr_last  = s_fire && (wr_cnt == CNT_LAST);
    assign m_fire   = m_axis_tvalid && m_axis_tready;
    // The output register may load whenever it is empty or being emptied.
    assign advance  = !m_axis_tvalid || m_axis_tready;
    assign rd_issue = (state == DRAIN) && !issued_all && advance;
    // Output index is column-major: low bits select the row, high bits the column.
    assign rd_addr  = {rd_cnt[LOG2N-1:0], rd_cnt[AW-1:LOG2N]};
    // The beat in flight once every address has been issued is the frame's last.
    assign out_last = m_fire && issued_all;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
        if (reset) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a full frame flips to DRAIN, the final output beat returns to FILL.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
        state_next = state;
        unique case (state)
            FILL:    if (wr_last)  state_next = DRAIN;
            DRAIN:   if (out_last) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    // Counters and the registered input ready, which follows the upcoming state.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt        <= '0;
            rd_cnt        <= '0;
            issued_all    <= 1'b0;
            s_axis_tready <= 1'b0;
        end else begin
            s_axis_tready <= (state_next == FILL);
            // Counter wraps to 0 after beat N*N-1; tlast never resynchronises it.
            if (s_fire) begin
                wr_cnt <= wr_cnt + 1'b1;
            end
            if (rd_issue) begin
                rd_cnt <= rd_cnt + 1'b1;
                if (rd_cnt == CNT_LAST) begin
                    issued_all <= 1'b1;
                end
            end
            if (out_last) begin
                issued_all <= 1'b0;
            end
        end
    end

    // Frame storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the RAM array is deliberately not reset so it maps onto block RAM.
        if (s_fire) begin
            mem[wr_cnt] <= s_axis_tdata;
        end
    end

    // Synchronous RAM read straight into the master output register, gated by advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (advance) begin
            m_axis_tvalid <= rd_issue;
            if (rd_issue) begin
                m_axis_tdata <= mem[rd_addr];
                m_axis_tlast <= (rd_cnt[LOG2N-1:0] == COL_LAST);
            end
        end
    end

    // Status pulses: frame completion and tlast framing errors, one cycle after the beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_done        <= 1'b0;
            err_tlast_early   <= 1'b0;
            err_tlast_missing <= 1'b0;
        end else begin
            frame_done        <= out_last;
            err_tlast_early   <= s_fire && s_axis_tlast && (wr_col != COL_LAST);
            err_tlast_missing <= s_fire && !s_axis_tlast && (wr_col == COL_LAST);
        end
    end

endmodule

// File: tb/tb_axis_transpose_buffer.sv
// Self-checking bench: a 4x4 instance for handshake/error/reset scenarios and a
// 128x128 instance for full-size throughput, both against a transpose model.
module tb_axis_transpose_buffer;

    localparam int NA = 4;
    localparam int NB = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    longint cyc = 0;
    // Free-running cycle counter for latency and bubble measurements.
    always @(posedge clk) cyc++;

    int unsigned n_pass   = 0;
    int unsigned n_checks = 0;

    // ---------------- small instance (N = 4) ----------------
    logic        a_reset;
    logic [31:0] a_s_tdata;
    logic        a_s_tvalid;
    logic        a_s_tready;
    logic        a_s_tlast;
    logic [31:0] a_m_tdata;
    logic        a_m_tvalid;
    logic        a_m_tready = 1'b1;
    logic        a_m_tlast;
    logic        a_frame_done;
    logic        a_err_early;
    logic        a_err_missing;

    axis_transpose_buffer #(.LOG2N(2), .DATA_W(32)) dut_a (
        .clk               (clk),
        .reset             (a_reset),
        .s_axis_tdata      (a_s_tdata),
        .s_axis_tvalid     (a_s_tvalid),
        .s_axis_tready     (a_s_tready),
        .s_axis_tlast      (a_s_tlast),
        .m_axis_tdata      (a_m_tdata),
        .m_axis_tvalid     (a_m_tvalid),
        .m_axis_tready     (a_m_tready),
        .m_axis_tlast      (a_m_tlast),
        .frame_done        (a_frame_done),
        .err_tlast_early   (a_err_early),
        .err_tlast_missing (a_err_missing)
    );

    // ---------------- large instance (N = 128) ----------------
    logic        b_reset;
    logic [31:0] b_s_tdata;
    logic        b_s_tvalid;
    logic        b_s_tready;
    logic        b_s_tlast;
    logic [31:0] b_m_tdata;
    logic        b_m_tvalid;
    logic        b_m_tready;
    logic        b_m_tlast;
    logic        b_frame_done;
    logic        b_err_early;
    logic        b_err_missing;

    axis_transpose_buffer #(.LOG2N(7), .DATA_W(32)) dut_b (
        .clk               (clk),
        .reset             (b_reset),
        .s_axis_tdata      (b_s_tdata),
        .s_axis_tvalid     (b_s_tvalid),
        .s_axis_tready     (b_s_tready),
        .s_axis_tlast      (b_s_tlast),
        .m_axis_tdata      (b_m_tdata),
        .m_axis_tvalid     (b_m_tvalid),
        .m_axis_tready     (b_m_tready),
        .m_axis_tlast      (b_m_tlast),
        .frame_done        (b_frame_done),
        .err_tlast_early   (b_err_early),
        .err_tlast_missing (b_err_missing)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference: output beat j of an n x n frame carries input beat (j mod n)*n + j/n.
    function automatic logic [32:0] model_small(input int base, input int j);
        int i;
        i = (j % NA) * NA + j / NA;
        return {((j % NA) == NA - 1), 32'(base + i)};
    endfunction

    function automatic logic [32:0] model_big(input int j);
        logic [15:0] i;
        i = 16'((j % NB) * NB + j / NB);
        return {((j % NB) == NB - 1), i, ~i};
    endfunction

    // ---------------- small-instance monitor ----------------
    logic [32:0] got_q[$];
    int          in_cnt    = 0;
    int          done_cnt  = 0;
    int          early_cnt = 0;
    int          early_at  = -1;
    int          miss_cnt  = 0;
    int          miss_at   = -1;
    int          rdy_viol  = 0;
    logic        prev_stall = 1'b0;
    logic [32:0] prev_beat  = '0;
    bit          rand_ready = 1'b0;

    // Observe the small instance mid-cycle: transfers, stall stability, pulses.
    always @(negedge clk) begin
        if (a_reset) begin
            prev_stall = 1'b0;
        end else begin
            if (a_err_early) begin
                early_cnt++;
                early_at = in_cnt - 1;
            end
            if (a_err_missing) begin
                miss_cnt++;
                miss_at = in_cnt - 1;
            end
            if (a_frame_done) begin
                done_cnt++;
                check("tready_at_done", a_s_tready, 1);
            end
            if (a_m_tvalid && a_s_tready) rdy_viol++;
            if (prev_stall) begin
                check("stall_hold", {a_m_tvalid, a_m_tlast, a_m_tdata}, {1'b1, prev_beat});
            end
            prev_stall = a_m_tvalid && !a_m_tready;
            prev_beat  = {a_m_tlast, a_m_tdata};
            if (a_m_tvalid && a_m_tready) got_q.push_back({a_m_tlast, a_m_tdata});
            if (a_s_tvalid && a_s_tready) in_cnt++;
        end
    end

    // Downstream ready: constant high or a random 50% pattern.
    always @(posedge clk) begin
        #1;
        a_m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic clear_stats();
        got_q.delete();
        in_cnt    = 0;
        done_cnt  = 0;
        early_cnt = 0;
        early_at  = -1;
        miss_cnt  = 0;
        miss_at   = -1;
        rdy_viol  = 0;
    endtask

    task automatic wait_accept();
        int   guard;
        logic took;
        guard = 0;
        do begin
            took = a_s_tready;
            @(posedge clk);
            #1;
            guard++;
        end while (!took && guard < 200);
        if (!took) check("in_accept_timeout", 0, 1);
    endtask

    task automatic send_frame(input int base, input int gap_pct, input int early_k, input int miss_k);
        for (int k = 0; k < NA * NA; k++) begin
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                a_s_tvalid = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            a_s_tvalid = 1'b1;
            a_s_tdata  = 32'(base + k);
            a_s_tlast  = ((k % NA) == NA - 1);
            if (k == early_k) a_s_tlast = 1'b1;
            if (k == miss_k)  a_s_tlast = 1'b0;
            wait_accept();
        end
        a_s_tvalid = 1'b0;
        a_s_tlast  = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int guard;
        guard = 0;
        while (done_cnt < target && guard < 500) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (done_cnt < target) check("frame_done_timeout", done_cnt, target);
    endtask

    task automatic expect_frame(input string tag, input int base, input int offs);
        check({tag, "_len"}, got_q.size() >= offs + NA * NA, 1);
        for (int j = 0; j < NA * NA; j++) begin
            if (offs + j < got_q.size()) check(tag, got_q[offs + j], model_small(base, j));
        end
    endtask

    // ---------------- large-instance monitor ----------------
    int     b_in_cnt        = 0;
    int     b_out_cnt       = 0;
    int     b_done_cnt      = 0;
    longint b_last_in_cyc   = -1;
    longint b_first_v_cyc   = -1;
    longint b_first_out_cyc = -1;
    longint b_last_out_cyc  = -1;

    // Observe the large instance: every output beat is compared with the model.
    always @(negedge clk) begin
        if (!b_reset) begin
            if (b_s_tvalid && b_s_tready) begin
                b_in_cnt++;
                if (b_in_cnt == NB * NB) b_last_in_cyc = cyc;
            end
            if (b_m_tvalid && b_first_v_cyc < 0) b_first_v_cyc = cyc;
            if (b_frame_done) b_done_cnt++;
            if (b_m_tvalid && b_m_tready) begin
                check("big_beat", {b_m_tlast, b_m_tdata}, model_big(b_out_cnt));
                if (b_out_cnt == 0) b_first_out_cyc = cyc;
                b_last_out_cyc = cyc;
                b_out_cnt++;
            end
        end
    end

    // Main sequence.
    initial begin
        int   guard;
        logic took;

        a_reset    = 1'b1;
        a_s_tvalid = 1'b0;
        a_s_tdata  = '0;
        a_s_tlast  = 1'b0;
        b_reset    = 1'b1;
        b_s_tvalid = 1'b0;
        b_s_tdata  = '0;
        b_s_tlast  = 1'b0;
        b_m_tready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_s_tready", a_s_tready, 0);
        check("rst_outputs", {a_m_tvalid, a_m_tlast, a_m_tdata}, 0);
        check("rst_pulses", {a_frame_done, a_err_early, a_err_missing}, 0);
        a_reset = 1'b0;
        @(posedge clk);
        #1;
        check("tready_after_reset", a_s_tready, 1);

        // Scenario: plain 4x4 frame, ready held high.
        clear_stats();
        send_frame(0, 0, -1, -1);
        wait_done(1);
        repeat (5) @(posedge clk);
        #1;
        expect_frame("basic", 0, 0);
        check("basic_done_once", done_cnt, 1);
        check("basic_no_err", early_cnt + miss_cnt, 0);
        check("basic_rdy_in_drain", rdy_viol, 0);

        // Scenario: random downstream stalls and upstream gaps.
        clear_stats();
        rand_ready = 1'b1;
        send_frame(0, 40, -1, -1);
        wait_done(1);
        rand_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        expect_frame("stall", 0, 0);
        check("stall_done_once", done_cnt, 1);

        // Scenario: tlast early on beat 2, missing on beat 3.
        clear_stats();
        send_frame(0, 0, 2, 3);
        wait_done(1);
        repeat (3) @(posedge clk);
        #1;
        check("early_cnt", early_cnt, 1);
        check("early_at", early_at, 2);
        check("miss_cnt", miss_cnt, 1);
        check("miss_at", miss_at, 3);
        expect_frame("err_order", 0, 0);

        // Scenario: reset after output beat 5 transfers, then a fresh frame.
        clear_stats();
        send_frame(0, 0, -1, -1);
        guard = 0;
        while (got_q.size() < 6 && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("reset_reach_beat5", got_q.size() >= 6, 1);
        a_reset = 1'b1;
        @(posedge clk);
        #1;
        a_reset = 1'b0;
        @(posedge clk);
        #1;
        check("abort_tvalid", a_m_tvalid, 0);
        check("abort_tready", a_s_tready, 1);
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt, 0);
        check("abort_no_err", early_cnt + miss_cnt, 0);
        clear_stats();
        send_frame(100, 0, -1, -1);
        wait_done(1);
        repeat (3) @(posedge clk);
        #1;
        expect_frame("after_abort", 100, 0);

        // Scenario: back-to-back frames; second frame waits out the first drain.
        clear_stats();
        send_frame(200, 0, -1, -1);
        send_frame(300, 0, -1, -1);
        wait_done(2);
        @(posedge clk);
        #1;
        check("b2b_tready_after", a_s_tready, 1);
        expect_frame("b2b_first", 200, 0);
        expect_frame("b2b_second", 300, NA * NA);
        check("b2b_rdy_in_drain", rdy_viol, 0);

        // Scenario: full-size 128x128 frame at one beat per clock.
        b_reset = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < NB * NB; k++) begin
            b_s_tvalid = 1'b1;
            b_s_tdata  = {k[15:0], ~k[15:0]};
            b_s_tlast  = ((k % NB) == NB - 1);
            guard = 0;
            do begin
                took = b_s_tready;
                @(posedge clk);
                #1;
                guard++;
            end while (!took && guard < 100);
            if (!took) begin
                check("big_accept_timeout", 0, 1);
                break;
            end
        end
        b_s_tvalid = 1'b0;
        b_s_tlast  = 1'b0;
        guard = 0;
        while (b_out_cnt < NB * NB && guard < 20000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("big_out_count", b_out_cnt, NB * NB);
        check("big_latency_ok", (b_first_v_cyc - b_last_in_cyc) <= 2 && b_last_in_cyc >= 0, 1);
        check("big_no_bubbles", b_last_out_cyc - b_first_out_cyc, NB * NB - 1);
        check("big_done_once", b_done_cnt, 1);
        check("big_no_err", {b_err_early, b_err_missing}, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axis_transpose_buffer.md
Name: axis_transpose_buffer

Overview:
- Full-frame corner-turn buffer between the row-FFT output (m_axis side of the first FFT core) and the column-FFT input.
- Accepts an N x N frame of complex samples on an AXI4-Stream slave in row-major order, one FFT frame per row, and stores it in block RAM.
- Replays the frame on an AXI4-Stream master in column-major order, with correct tvalid/tready/tlast handshaking.
- Provides the handshaked sink for FFT output and the source for the transposed second-pass input.

Parameters:
- LOG2N, 7, log2 of frame side N (N = 128 by default; N x N words stored).
- DATA_W, 32, sample width; tdata[31:16] is imaginary and tdata[15:0] is real; the block passes data through unmodified.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- s_axis_tdata  in  DATA_W  row-FFT output sample.
- s_axis_tvalid  in  1  input sample valid.
- s_axis_tready  out  1  buffer accepting input (FILL state only).
- s_axis_tlast  in  1  end of one row (one FFT frame).
- m_axis_tdata  out  DATA_W  transposed sample.
- m_axis_tvalid  out  1  output sample valid.
- m_axis_tready  in  1  downstream (column FFT) ready.
- m_axis_tlast  out  1  end of one column.
- frame_done  out  1  one-cycle pulse when the last output beat transfers.
- err_tlast_early  out  1  one-cycle pulse: tlast seen on a beat with column != N-1.
- err_tlast_missing  out  1  one-cycle pulse: no tlast on a beat with column == N-1.

Behaviour:
- Reset values: s_axis_tready=0 during reset and 1 the cycle after reset deasserts; m_axis_tvalid=0; m_axis_tlast=0; m_axis_tdata=0; frame_done=0; both error pulses 0.
- Reset effect: counters cleared, state set to FILL. RAM contents are not cleared.
- States: FILL, DRAIN.
- FILL:
  - s_axis_tready=1; a beat transfers when tvalid and tready are both high.
  - Write address is wr_cnt (0 .. N*N-1), so row = wr_cnt[2*LOG2N-1:LOG2N] and column = wr_cnt[LOG2N-1:0].
  - tlast is checked on every transferred beat against column==N-1. A mismatch pulses the matching error output on the cycle after the beat.
  - Data is always stored and wr_cnt always advances; tlast never resynchronises the counter.
  - On transfer of beat N*N-1: wr_cnt returns to 0, state goes to DRAIN, and s_axis_tready drops on the next cycle.
- DRAIN:
  - s_axis_tready=0.
  - Output index rd_cnt runs 0 .. N*N-1, with c = rd_cnt[2*LOG2N-1:LOG2N] and r = rd_cnt[LOG2N-1:0]. Read address = r*N + c, so output beat k carries input beat (k mod N)*N + k/N.
  - m_axis_tlast = 1 when r == N-1.
  - Latency: the last input beat transfers in cycle T; the first m_axis_tvalid is high no later than cycle T+2.
  - AXI rules:
    - Once tvalid is high, tdata and tlast hold stable until tready is seen.
    - tvalid never drops without a transfer.
    - Sustained one beat per clock while m_axis_tready is held high.
    - Any tready stall pattern must lose no beat and duplicate no beat.
  - The RAM read is synchronous (1 cycle). Implement with an output register plus a skid register, or read-enable = !m_axis_tvalid || m_axis_tready.
  - On transfer of the beat with rd_cnt = N*N-1: frame_done pulses the next cycle, m_axis_tvalid goes to 0, state returns to FILL, and s_axis_tready=1 on the cycle after the transfer.
- Inputs presented during DRAIN are not accepted (tready=0); the upstream core must back-pressure or buffer.
- Reset mid-FILL or mid-DRAIN aborts the frame: no frame_done, no error pulses, and the partial frame is discarded.
- Error pulses never block flow.

Test Plan:
- LOG2N=2, input tdata=k for k=0..15 with tlast on k=3,7,11,15, m_axis_tready=1 -> output 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15. tlast on output beats 3,7,11,15. frame_done pulses once; no error pulses.
- LOG2N=7, input tdata={k[15:0],~k[15:0]} for k=0..16383, ready constant high -> output beat j equals input beat (j%128)*128 + j/128. First output tvalid at or before last-input cycle + 2. 16384 consecutive transfers with no bubbles.
- LOG2N=2, random m_axis_tready (50%) and random s_axis_tvalid gaps -> same 16-value sequence as the first scenario. tdata/tlast stable whenever tvalid=1 and tready=0. tvalid never drops without a transfer.
- LOG2N=2, tlast asserted on k=2 and omitted on k=3 -> err_tlast_early pulses after k=2. err_tlast_missing pulses after k=3. Output order unchanged.
- LOG2N=2, reset after output beat 5 transfers -> next cycle m_axis_tvalid=0 and s_axis_tready=1, no frame_done. A fresh frame of values 100..115 then outputs 100,104,108,112,101,...
- Back-to-back frames, LOG2N=2 -> s_axis_tready=0 for the whole DRAIN and 1 the cycle after the second frame_done. Second-frame output is correctly transposed.
